ccd_frame_capture: RTL and testbench



---
 rtl/ccd_capture_pkg.sv | 34 +++
 rtl/ccd_edge_sync.sv | 29 ++
 rtl/ccd_frame_capture.sv | 205 ++++++++++++++++++++
 tb/tb_ccd_frame_capture.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccd_capture_pkg.sv
// Shared types and default widths for the CCD frame capture stage.
// Mode decoding lives here so every user maps the reserved code the same way.
package ccd_capture_pkg;

  localparam int DEF_DATA_W  = 12;
  localparam int DEF_X_W     = 16;
  localparam int DEF_Y_W     = 16;
  localparam int DEF_FRAME_W = 32;
  localparam int DEF_BURST_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_CONT   = 2'd0,
    MODE_SINGLE = 2'd1,
    MODE_BURST  = 2'd2
  } mode_t;

  // The reserved code 3 behaves as single-shot.
  function automatic mode_t decodeMode(input logic [1:0] raw);
    mode_t m;
    case (raw)
      2'd0:    m = MODE_CONT;
      2'd2:    m = MODE_BURST;
      default: m = MODE_SINGLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ccd_edge_sync.sv
// One register stage on a camera/control level plus rise and fall pulses
// derived from the registered copy.
module ccd_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= d_i;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/ccd_frame_capture.sv
// CCD capture stage: frame-aligned start/stop, continuous/single/burst modes
// and a region-of-interest window in front of the Bayer converter.
module ccd_frame_capture
  import ccd_capture_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [DATA_W-1:0]  iDATA,
  input  logic               iFVAL,
  input  logic               iLVAL,
  input  logic               iSTART,
  input  logic               iSTOP,
  input  logic [1:0]         iMODE,
  input  logic [BURST_W-1:0] iBURST_N,
  input  logic [X_W-1:0]     iX_START,
  input  logic [X_W-1:0]     iX_END,
  input  logic [Y_W-1:0]     iY_START,
  input  logic [Y_W-1:0]     iY_END,
  output logic [DATA_W-1:0]  oDATA,
  output logic               oDVAL,
  output logic [X_W-1:0]     oX_Cont,
  output logic [Y_W-1:0]     oY_Cont,
  output logic [FRAME_W-1:0] oFrame_Cont,
  output logic               oBUSY,
  output logic               oDONE
);

  logic fvalRise, fvalFall, lvalLvl, lvalFall, startRise, stopRise;
  logic unusedFvalLvl, unusedLvalRise;
  logic unusedStartLvl, unusedStartFall, unusedStopLvl, unusedStopFall;

  ccd_edge_sync uFval (
    .clk_i(iCLK), .rst_ni(iRST_N), .d_i(iFVAL),
    .q_o(unusedFvalLvl), .rise_o(fvalRise), .fall_o(fvalFall)
  );

  ccd_edge_sync uLval (
    .clk_i(iCLK), .rst_ni(iRST_N), .d_i(iLVAL),
    .q_o(lvalLvl), .rise_o(unusedLvalRise), .fall_o(lvalFall)
  );

  ccd_edge_sync uStart (
    .clk_i(iCLK), .rst_ni(iRST_N), .d_i(iSTART),
    .q_o(unusedStartLvl), .rise_o(startRise), .fall_o(unusedStartFall)
  );

  ccd_edge_sync uStop (
    .clk_i(iCLK), .rst_ni(iRST_N), .d_i(iSTOP),
    .q_o(unusedStopLvl), .rise_o(stopRise), .fall_o(unusedStopFall)
  );

  state_t               state_q, state_d;
  mode_t                mode_q, mode_d;
  logic [BURST_W-1:0]   burstN_q, burstN_d;
  logic [BURST_W-1:0]   burstCnt_q, burstCnt_d;
  logic                 stopPend_q, stopPend_d;
  logic                 done_q, done_d;
  logic [FRAME_W-1:0]   frameCnt_q, frameCnt_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic [DATA_W-1:0]    data_q;
  logic [DATA_W-1:0]    outData_q, outData_d;
  logic                 outDval_q, outDval_d;
  logic [X_W-1:0]       outX_q, outX_d;
  logic [Y_W-1:0]       outY_q, outY_d;

  logic [BURST_W:0]     burstNext;
  logic [BURST_W:0]     burstTarget;
  logic                 pixelNow;
  logic                 inWindow;
  logic                 endSeq;

  assign burstNext   = {1'b0, burstCnt_q} + 1'b1;
  assign burstTarget = (burstN_q == '0) ? {{BURST_W{1'b0}}, 1'b1} : {1'b0, burstN_q};
  assign pixelNow    = (state_q == CAPTURE) && lvalLvl;
  assign inWindow    = (x_q >= iX_START) && (x_q <= iX_END) &&
                       (y_q >= iY_START) && (y_q <= iY_END);

  // Sequencer plus counters; x_q/y_q name the pixel currently on the registered inputs.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    burstN_d   = burstN_q;
    burstCnt_d = burstCnt_q;
    stopPend_d = stopPend_q;
    done_d     = 1'b0;
    frameCnt_d = frameCnt_q;
    x_d        = x_q;
    y_d        = y_q;
    endSeq     = 1'b0;

    case (state_q)
      IDLE: begin
        if (startRise) begin
          mode_d     = decodeMode(iMODE);
          burstN_d   = iBURST_N;
          burstCnt_d = '0;
          stopPend_d = stopRise;
          state_d    = ARMED;
        end
      end

      ARMED: begin
        if (stopRise || stopPend_q) begin
          stopPend_d = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else if (fvalRise) begin
          x_d     = '0;
          y_d     = '0;
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        if (lvalLvl) begin
          x_d = (&x_q) ? x_q : x_q + 1'b1;
        end else if (lvalFall) begin
          x_d = '0;
          y_d = (&y_q) ? y_q : y_q + 1'b1;
        end
        if (stopRise) begin
          stopPend_d = 1'b1;
        end
        if (fvalFall) begin
          frameCnt_d = frameCnt_q + 1'b1;
          burstCnt_d = burstNext[BURST_W-1:0];
          endSeq     = stopPend_q || stopRise || (mode_q == MODE_SINGLE) ||
                       ((mode_q == MODE_BURST) && (burstNext >= burstTarget));
          if (endSeq) begin
            stopPend_d = 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = ARMED;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Output stage: coordinates and data hold their last captured value between pixels.
  always_comb begin
    outData_d = outData_q;
    outX_d    = outX_q;
    outY_d    = outY_q;
    outDval_d = pixelNow && inWindow;
    if (pixelNow) begin
      outData_d = data_q;
      outX_d    = x_q;
      outY_d    = y_q;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= IDLE;
      mode_q     <= MODE_SINGLE;
      burstN_q   <= '0;
      burstCnt_q <= '0;
      stopPend_q <= 1'b0;
      done_q     <= 1'b0;
      frameCnt_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      data_q     <= '0;
      outData_q  <= '0;
      outDval_q  <= 1'b0;
      outX_q     <= '0;
      outY_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      burstN_q   <= burstN_d;
      burstCnt_q <= burstCnt_d;
      stopPend_q <= stopPend_d;
      done_q     <= done_d;
      frameCnt_q <= frameCnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      data_q     <= iDATA;
      outData_q  <= outData_d;
      outDval_q  <= outDval_d;
      outX_q     <= outX_d;
      outY_q     <= outY_d;
    end
  end

  assign oDATA       = outData_q;
  assign oDVAL       = outDval_q;
  assign oX_Cont     = outX_q;
  assign oY_Cont     = outY_q;
  assign oFrame_Cont = frameCnt_q;
  assign oBUSY       = (state_q != IDLE);
  assign oDONE       = done_q;

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Bench for ccd_frame_capture: table-driven capture scenarios, randomized
// windows/modes against a frame-level reference model, plus reset corner cases.
module tb_ccd_frame_capture;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [11:0] data = '0;
  logic        fval = 1'b0, lval = 1'b0, start = 1'b0, stop = 1'b0;
  logic [1:0]  mode = 2'd1;
  logic [7:0]  burstN = 8'd1;
  logic [15:0] xs = '0, xe = '0, ys = '0, ye = '0;

  logic [11:0] oData;
  logic        oDval, oBusy, oDone;
  logic [15:0] oX, oY;
  logic [31:0] oFrame;

  logic [2:0]  sXs = 3'd0, sXe = 3'd7;
  logic [15:0] sYs = 16'd0, sYe = 16'hFFFF;
  logic [11:0] unusedSData;
  logic        sDval, unusedSBusy, unusedSDone;
  logic [2:0]  sX;
  logic [15:0] unusedSY;
  logic [31:0] unusedSFrame;

  always #5 clk = ~clk;

  ccd_frame_capture dut (
    .iCLK(clk), .iRST_N(rstN), .iDATA(data), .iFVAL(fval), .iLVAL(lval),
    .iSTART(start), .iSTOP(stop), .iMODE(mode), .iBURST_N(burstN),
    .iX_START(xs), .iX_END(xe), .iY_START(ys), .iY_END(ye),
    .oDATA(oData), .oDVAL(oDval), .oX_Cont(oX), .oY_Cont(oY),
    .oFrame_Cont(oFrame), .oBUSY(oBusy), .oDONE(oDone)
  );

  // Narrow column counter to exercise saturation alongside the main instance.
  ccd_frame_capture #(.X_W(3)) dutSat (
    .iCLK(clk), .iRST_N(rstN), .iDATA(data), .iFVAL(fval), .iLVAL(lval),
    .iSTART(start), .iSTOP(stop), .iMODE(mode), .iBURST_N(burstN),
    .iX_START(sXs), .iX_END(sXe), .iY_START(sYs), .iY_END(sYe),
    .oDATA(unusedSData), .oDVAL(sDval), .oX_Cont(sX), .oY_Cont(unusedSY),
    .oFrame_Cont(unusedSFrame), .oBUSY(unusedSBusy), .oDONE(unusedSDone)
  );

  typedef struct {
    logic [11:0] d;
    int          x;
    int          y;
    longint      t;
  } pix_t;

  typedef struct {
    int mode;
    int burstN;
    int w;
    int h;
    int xs;
    int xe;
    int ys;
    int ye;
    int nFrames;
    int stopFrame;
    int sat;
    int expDval;
    int expFrames;
    int expDone;
    int expBusy;
  } vec_t;

  int     nCompared = 0;
  int     nMismatched = 0;
  int     dvalSeen = 0;
  int     doneSeen = 0;
  bit     satCheck = 1'b0;
  longint cyc = 0;
  pix_t   expQ[$];
  int     satQ[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard: every valid pixel must be the next expected one, on its exact cycle.
  always @(negedge clk) begin
    if (oDone) doneSeen++;
    if (oDval) begin
      dvalSeen++;
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL extraPixel: got pixel at x=%0d y=%0d, expected none", oX, oY);
      end else begin
        pix_t e;
        e = expQ.pop_front();
        checkOutput("pixData", oData, e.d);
        checkOutput("pixX", oX, e.x);
        checkOutput("pixY", oY, e.y);
        checkOutput("pixCycle", cyc, e.t);
      end
    end
    if (satCheck && sDval) begin
      if (satQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL satExtra: got sat pixel x=%0d, expected none", sX);
      end else begin
        checkOutput("satX", sX, satQ.pop_front());
      end
    end
  end

  function automatic bit inWin(input int x, input int y);
    return (x >= int'(xs)) && (x <= int'(xe)) && (y >= int'(ys)) && (y <= int'(ye));
  endfunction

  // How many frames after arming the sequence may take (before supply runs out).
  function automatic int capLimit(input int m, input int n, input int stopF);
    int lim;
    if (m == 0) lim = 1000;
    else if (m == 2) lim = (n == 0) ? 1 : n;
    else lim = 1;
    if (stopF > 0 && stopF < lim) lim = stopF;
    return lim;
  endfunction

  task automatic pulse(input bit isStart);
    if (isStart) start = 1'b1; else stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
  endtask

  // One full frame; control pulses and an optional reset land in the gap after a line.
  task automatic applyStimulus(input int w, input int h, input bit cap,
                               input bit doStart, input bit doStop, input int resetLine);
    bit capNow;
    capNow = cap;
    fval = 1'b1;
    tick();
    tick();
    for (int y = 0; y < h; y++) begin
      lval = 1'b1;
      for (int x = 0; x < w; x++) begin
        data = 12'($urandom);
        if (capNow && inWin(x, y)) expQ.push_back('{d: data, x: x, y: y, t: cyc + 2});
        if (capNow && satCheck) satQ.push_back((x > 7) ? 7 : x);
        tick();
      end
      lval = 1'b0;
      data = '0;
      repeat (3) tick();
      if (y == 0 && doStart) pulse(1'b1);
      if (y == 0 && doStop) pulse(1'b0);
      if (y == resetLine) begin
        rstN = 1'b0;
        #1;
        checkOutput("midResetOutputs",
                    {oData, oDval, oX, oY, oFrame, oBusy, oDone}, '0);
        tick();
        rstN = 1'b1;
        capNow = 1'b0;
        tick();
        pulse(1'b1);
      end
    end
    fval = 1'b0;
    repeat (4) tick();
  endtask

  task automatic resetDut();
    rstN = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    fval = 1'b0;
    lval = 1'b0;
    data = '0;
    tick();
    tick();
    checkOutput("resetState", {oData, oDval, oX, oY, oFrame, oBusy, oDone}, '0);
    rstN = 1'b1;
    tick();
    dvalSeen = 0;
    doneSeen = 0;
    expQ.delete();
    satQ.delete();
  endtask

  task automatic runCase(input vec_t v);
    int lim;
    mode = 2'(v.mode);
    burstN = 8'(v.burstN);
    xs = 16'(v.xs);
    xe = 16'(v.xe);
    ys = 16'(v.ys);
    ye = 16'(v.ye);
    resetDut();
    satCheck = (v.sat != 0);
    lim = capLimit(v.mode, v.burstN, v.stopFrame);
    for (int f = 0; f < v.nFrames; f++) begin
      applyStimulus(v.w, v.h, (f >= 1) && (f <= lim), f == 0,
                    (v.stopFrame > 0) && (f == v.stopFrame), -1);
    end
    repeat (6) tick();
    checkOutput("queueEmpty", expQ.size(), 0);
    checkOutput("satQueueEmpty", satQ.size(), 0);
    checkOutput("dvalCount", dvalSeen, v.expDval);
    checkOutput("frameCount", oFrame, v.expFrames);
    checkOutput("doneCount", doneSeen, v.expDone);
    checkOutput("busyAfter", oBusy, v.expBusy);
    satCheck = 1'b0;
  endtask

  vec_t tbl[9];

  initial begin
    // mode N  w  h  xs xe ys ye nF stop sat dval fr done busy
    tbl[0] = '{1, 0,  8, 4, 0, 7, 0, 3, 3, 0, 0,  32, 1, 1, 0};
    tbl[1] = '{2, 3,  8, 4, 0, 7, 0, 3, 6, 0, 0,  96, 3, 1, 0};
    tbl[2] = '{2, 0,  8, 4, 0, 7, 0, 3, 4, 0, 0,  32, 1, 1, 0};
    tbl[3] = '{0, 0,  8, 4, 0, 7, 0, 3, 4, 2, 0,  64, 2, 1, 0};
    tbl[4] = '{1, 0, 16, 8, 4, 7, 2, 3, 3, 0, 0,   8, 1, 1, 0};
    tbl[5] = '{1, 0, 16, 8, 9, 3, 2, 3, 3, 0, 0,   0, 1, 1, 0};
    tbl[6] = '{0, 0,  4, 2, 0, 3, 0, 1, 3, 0, 0,  16, 2, 0, 1};
    tbl[7] = '{3, 5,  4, 3, 0, 3, 0, 2, 3, 0, 0,  12, 1, 1, 0};
    tbl[8] = '{1, 0, 12, 2, 0, 15, 0, 15, 3, 0, 1, 24, 1, 1, 0};

    for (int i = 0; i < 9; i++) runCase(tbl[i]);

    for (int r = 0; r < 6; r++) begin
      vec_t v;
      int lim, captured, winCnt;
      v.mode = $urandom_range(0, 3);
      v.burstN = $urandom_range(0, 3);
      v.w = $urandom_range(2, 10);
      v.h = $urandom_range(1, 5);
      v.xs = $urandom_range(0, 11);
      v.xe = $urandom_range(0, 11);
      v.ys = $urandom_range(0, 5);
      v.ye = $urandom_range(0, 5);
      v.nFrames = $urandom_range(2, 5);
      v.stopFrame = $urandom_range(0, v.nFrames - 1);
      v.sat = 0;
      lim = capLimit(v.mode, v.burstN, v.stopFrame);
      captured = (lim < v.nFrames - 1) ? lim : v.nFrames - 1;
      winCnt = 0;
      for (int y = 0; y < v.h; y++)
        for (int x = 0; x < v.w; x++)
          if (x >= v.xs && x <= v.xe && y >= v.ys && y <= v.ye) winCnt++;
      v.expDval = captured * winCnt;
      v.expFrames = captured;
      v.expDone = (lim <= v.nFrames - 1) ? 1 : 0;
      v.expBusy = 1 - v.expDone;
      runCase(v);
    end

    // Start and stop edges together: start wins, stop ends the sequence next cycle.
    mode = 2'd1;
    xs = 16'd0; xe = 16'd15; ys = 16'd0; ye = 16'd15;
    resetDut();
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    repeat (6) tick();
    checkOutput("simulDone", doneSeen, 1);
    checkOutput("simulBusy", oBusy, 0);
    applyStimulus(4, 2, 1'b0, 1'b0, 1'b0, -1);
    repeat (4) tick();
    checkOutput("simulNoPixels", dvalSeen, 0);
    checkOutput("simulFrames", oFrame, 0);

    // Reset in the middle of a captured frame, then rearm mid-frame.
    resetDut();
    applyStimulus(6, 4, 1'b0, 1'b1, 1'b0, -1);
    applyStimulus(6, 4, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("rearmBusy", oBusy, 1);
    applyStimulus(6, 4, 1'b1, 1'b0, 1'b0, -1);
    repeat (6) tick();
    checkOutput("rstQueueEmpty", expQ.size(), 0);
    checkOutput("rstDvalCount", dvalSeen, 36);
    checkOutput("rstFrames", oFrame, 1);
    checkOutput("rstDone", doneSeen, 1);
    checkOutput("rstBusy", oBusy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
